// File: rtl/controller_spi_pkg.sv
// controller_spi_pkg: register map and status bit positions shared by the SPI master and slave
package controller_spi_pkg;
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam int ROE_BIT  = 3;
  localparam int TOE_BIT  = 4;
  localparam int TUE_BIT  = 5;
  localparam int TRDY_BIT = 6;
  localparam int RRDY_BIT = 7;
  localparam int E_BIT    = 8;
  typedef struct packed {
    logic rrdy;
    logic trdy;
    logic tue;
    logic toe;
    logic roe;
  } spi_flags_t;
  function automatic logic [15:0] status_word(input spi_flags_t f);
    logic [15:0] w;
    w = '0;
    w[ROE_BIT]  = f.roe;
    w[TOE_BIT]  = f.toe;
    w[TUE_BIT]  = f.tue;
    w[TRDY_BIT] = f.trdy;
    w[RRDY_BIT] = f.rrdy;
    w[E_BIT]    = f.roe | f.toe | f.tue;
    return w;
  endfunction
endpackage

// File: rtl/controller_spis_sync.sv
// controller_spis_sync: synchronizers and edge detect for the asynchronous SPI pins
module controller_spis_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic ss_n_s,
  output logic mosi_s
);
  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
  logic sclk_d, ss_d;
  // ss chain clears low so a select held through reset never looks like a fresh falling edge
  always_ff @(posedge clk)
    if (reset) begin
      sclk_q <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_d   <= 1'b0;
    end else begin
      sclk_q <= SYNC_STAGES'({sclk_q, sclk});
      ss_q   <= SYNC_STAGES'({ss_q, ss_n});
      mosi_q <= SYNC_STAGES'({mosi_q, mosi});
      sclk_d <= sclk_q[SYNC_STAGES-1];
      ss_d   <= ss_q[SYNC_STAGES-1];
    end
  assign ss_n_s    = ss_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_d & sclk_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_q[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss_n_s;
  assign ss_rise   = ~ss_d & ss_n_s;
endmodule

// File: rtl/controller_spis_1.sv
// controller_spis_1: SPI mode-0 slave with one-byte TX/RX holding registers and CPU register interface
module controller_spis_1
  import controller_spi_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] UNDERRUN_FILL = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_shift, tx_holding, rx_holding;
  logic [6:0]  rx_shift;
  logic [5:0]  control;
  logic        tx_full, rrdy, roe, toe, tue, armed;
  logic        sclk_rise, sclk_fall, ss_fall, ss_rise, ss_n_s, mosi_s;
  logic        wr, rd, wr_tx, clr_err, byte_done, load, tx_accept;
  logic [15:0] status, rd_data;
  logic        unused_bits;
  controller_spis_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .sclk(SCLK), .ss_n(SS_n), .mosi(MOSI),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .ss_fall(ss_fall),
    .ss_rise(ss_rise), .ss_n_s(ss_n_s), .mosi_s(mosi_s)
  );
  assign wr        = spi_select & ~write_n;
  assign rd        = spi_select & ~read_n;
  assign wr_tx     = wr && mem_addr == ADDR_TXDATA;
  assign clr_err   = wr && mem_addr == ADDR_STATUS;
  assign byte_done = state == SHIFT && !ss_rise && sclk_rise && bit_cnt == 3'd7;
  assign load      = (state == IDLE && ss_fall) || byte_done;
  // a write that lands on a shift load is accepted: the load takes the old byte
  assign tx_accept = wr_tx && (!tx_full || load);
  assign status    = status_word(spi_flags_t'{rrdy: rrdy, trdy: ~tx_full, tue: tue, toe: toe, roe: roe});
  assign MISO_oe   = armed & ~ss_n_s;
  assign MISO      = MISO_oe & tx_shift[7];
  assign dataavailable = rrdy;
  assign readyfordata  = ~tx_full;
  assign unused_bits   = ^data_from_cpu[15:9];
  always_comb
    rd_data = mem_addr == ADDR_RXDATA  ? {8'h00, rx_holding} :
              mem_addr == ADDR_STATUS  ? status :
              mem_addr == ADDR_CONTROL ? {7'h00, control, 3'h0} : 16'h0000;
  always_ff @(posedge clk)
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      tx_shift    <= 8'h00;
      rx_shift    <= 7'h00;
      tx_holding  <= 8'h00;
      rx_holding  <= 8'h00;
      tx_full     <= 1'b0;
      rrdy        <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      tue         <= 1'b0;
      armed       <= 1'b0;
      control     <= 6'h00;
      data_to_cpu <= 16'h0000;
      irq         <= 1'b0;
    end else begin
      armed <= armed | ss_n_s;
      if (state == SHIFT && ss_rise) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
      end else if (state == IDLE && ss_fall) begin
        state   <= SHIFT;
        bit_cnt <= 3'd0;
      end else if (state == SHIFT && sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (byte_done)
        rx_holding <= {rx_shift, mosi_s};
      if (load)
        tx_shift <= tx_full ? tx_holding : UNDERRUN_FILL;
      else if (state == SHIFT && !ss_rise && sclk_fall && bit_cnt != 3'd0)
        tx_shift <= {tx_shift[6:0], 1'b0};
      if (tx_accept) begin
        tx_holding <= data_from_cpu[7:0];
        tx_full    <= 1'b1;
      end else if (load)
        tx_full <= 1'b0;
      rrdy <= byte_done | (rrdy & ~(rd && mem_addr == ADDR_RXDATA));
      roe  <= (byte_done & rrdy) | (roe & ~clr_err);
      toe  <= (wr_tx & ~tx_accept) | (toe & ~clr_err);
      tue  <= (load & ~tx_full) | (tue & ~clr_err);
      if (wr && mem_addr == ADDR_CONTROL)
        control <= data_from_cpu[E_BIT:ROE_BIT];
      if (rd)
        data_to_cpu <= rd_data;
      irq <= |(status[E_BIT:ROE_BIT] & control);
    end
endmodule

// File: tb/tb_controller_spis_1.sv
// tb_controller_spis_1: directed scenarios plus random CPU/SPI traffic against a register-level model
module tb_controller_spis_1;
  logic        clk = 1'b0, reset = 1'b1;
  logic        SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic        spi_select = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'h0;
  logic        MISO, MISO_oe, irq, dataavailable, readyfordata;
  logic [15:0] data_to_cpu;
  int n_cmp = 0, n_bad = 0;
  logic [7:0]  m_out [4];
  logic [7:0]  m_in [4];
  logic [7:0]  exp_miso [4];
  logic        full, rrdy, roe, toe, tue;
  logic [7:0]  txb, rx;
  logic [5:0]  ctrl;
  always #5 clk = ~clk;
  controller_spis_1 dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr), .spi_select(spi_select),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
    .readyfordata(readyfordata)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] m_status();
    return {7'b0, roe | toe | tue, rrdy, ~full, tue, toe, roe, 3'b0};
  endfunction
  task automatic model_reset();
    {full, rrdy, roe, toe, tue} = '0;
    txb = 8'h00; rx = 8'h00; ctrl = 6'h00;
  endtask
  task automatic take(output logic [7:0] b);
    if (full) begin
      full = 1'b0;
      b = txb;
    end else begin
      tue = 1'b1;
      b = 8'h00;
    end
  endtask
  task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
    mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask
  task automatic cpu_rd(input logic [2:0] a, output logic [15:0] d);
    mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
    @(negedge clk);
    spi_select = 1'b0; read_n = 1'b1;
    d = data_to_cpu;
  endtask
  task automatic do_wr(input logic [2:0] a, input logic [15:0] d);
    cpu_wr(a, d);
    if (a == 3'd1) begin
      if (full) toe = 1'b1;
      else begin
        full = 1'b1;
        txb = d[7:0];
      end
    end else if (a == 3'd2) {roe, toe, tue} = '0;
    else if (a == 3'd3) ctrl = d[8:3];
  endtask
  task automatic do_rd(input logic [2:0] a);
    logic [15:0] e, d;
    e = a == 3'd0 ? {8'h00, rx} : a == 3'd2 ? m_status() : a == 3'd3 ? {7'h00, ctrl, 3'h0} : 16'h0;
    cpu_rd(a, d);
    check($sformatf("rd%0d", a), d, e);
    if (a == 3'd0) rrdy = 1'b0;
  endtask
  task automatic check_pins();
    logic [15:0] s;
    repeat (2) @(negedge clk);
    s = m_status();
    check("dataavailable", {15'h0, dataavailable}, {15'h0, rrdy});
    check("readyfordata", {15'h0, readyfordata}, {15'h0, ~full});
    check("irq", {15'h0, irq}, {15'h0, |(s[8:3] & ctrl)});
    check("oe_idle", {15'h0, MISO_oe}, 16'h0);
  endtask
  task automatic spi_bit(input logic b, output logic r);
    MOSI = b;
    repeat (6) @(negedge clk);
    SCLK = 1'b1;
    r = MISO;
    repeat (6) @(negedge clk);
    SCLK = 1'b0;
  endtask
  task automatic xfer(input int nbits);
    logic r;
    int nb;
    nb = nbits / 8;
    SS_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(m_out[i / 8][7 - i % 8], r);
      m_in[i / 8][7 - i % 8] = r;
    end
    repeat (6) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    take(exp_miso[0]);
    for (int k = 0; k < nb; k++) begin
      check($sformatf("miso%0d", k), {8'h00, m_in[k]}, {8'h00, exp_miso[k]});
      roe = roe | rrdy;
      rrdy = 1'b1;
      rx = m_out[k];
      take(exp_miso[k + 1]);
    end
  endtask
  task automatic check_reset_pins(input string tag);
    check({tag, "_miso"}, {15'h0, MISO}, 16'h0);
    check({tag, "_oe"}, {15'h0, MISO_oe}, 16'h0);
    check({tag, "_irq"}, {15'h0, irq}, 16'h0);
    check({tag, "_dout"}, data_to_cpu, 16'h0);
    check({tag, "_rrdy"}, {15'h0, dataavailable}, 16'h0);
    check({tag, "_trdy"}, {15'h0, readyfordata}, 16'h1);
  endtask
  initial begin
    logic r;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_pins("rst");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    // write 0xA5, master sends 0x3C
    do_wr(3'd1, 16'h00A5);
    m_out[0] = 8'h3C;
    xfer(8);
    check("a5_seen", {8'h00, m_in[0]}, 16'h00A5);
    check_pins();
    do_rd(3'd0);
    check("rx_3c", data_to_cpu, 16'h003C);
    // two underrun bytes with TUE interrupt enabled; second byte also overruns RX
    do_wr(3'd2, 16'h0);
    do_wr(3'd3, 16'h0020);
    m_out[0] = 8'h5A; m_out[1] = 8'hC3;
    xfer(16);
    check_pins();
    check("irq_tue", {15'h0, irq}, 16'h1);
    do_rd(3'd2);
    do_rd(3'd0);
    check("rx_second", data_to_cpu, 16'h00C3);
    // TX overrun: second write is dropped
    do_wr(3'd2, 16'h0);
    do_wr(3'd3, 16'h0);
    do_wr(3'd1, 16'h0011);
    do_wr(3'd1, 16'h0022);
    do_rd(3'd2);
    m_out[0] = 8'hE7;
    xfer(8);
    check("tx_11", {8'h00, m_in[0]}, 16'h0011);
    // aborted partial byte, then a full 0x81
    do_rd(3'd0);
    do_wr(3'd2, 16'h0);
    m_out[0] = 8'hFF;
    xfer(4);
    check_pins();
    m_out[0] = 8'h81;
    xfer(8);
    do_rd(3'd2);
    do_rd(3'd0);
    check("rx_81", data_to_cpu, 16'h0081);
    // reset in the middle of a byte, select held low across it
    do_wr(3'd1, 16'h0077);
    SS_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_pins("midrst");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
    check("oe_no_fresh_fall", {15'h0, MISO_oe}, 16'h0);
    repeat (6) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    model_reset();
    do_rd(3'd2);
    do_wr(3'd1, 16'h0096);
    m_out[0] = 8'h4D;
    xfer(8);
    do_rd(3'd0);
    check_pins();
    // random traffic
    for (int it = 0; it < 80; it++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op == 0) do_wr(3'd1, 16'($urandom));
      else if (op == 1) do_wr(3'd3, 16'($urandom));
      else if (op == 2) do_wr(3'd2, 16'($urandom));
      else if (op == 3) do_rd(3'($urandom_range(0, 7)));
      else begin
        for (int k = 0; k < 4; k++) m_out[k] = 8'($urandom);
        xfer($urandom_range(1, 24));
      end
      check_pins();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
